// File: rtl/ariane_pkg.sv
// ariane_pkg: interface types exchanged between the branch unit, the
// branch history table and the frontend.
//   cf_t         - control-flow descriptor of a resolved instruction.
//   bp_resolve_t - resolution record produced by the execute-stage branch unit.
//   bht_pred_t   - {valid, taken} direction prediction returned to fetch.
package ariane_pkg;

    typedef struct packed {
        logic [1:0] kind;   // control-flow class, not used by the BHT
        logic       taken;  // resolved direction
    } cf_t;

    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target_address;
        logic                   is_mispredict;
        logic [4:0]             to_reg;
        cf_t                    cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_pred_t;

endpackage

// File: rtl/bht_resolve_pkg.sv
// bht_resolve_pkg: local definitions for the branch history table.
//   bht_state_e - sweep/run control state.
//   CTR_*       - 2-bit saturating counter encodings.
package bht_resolve_pkg;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } bht_state_e;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

endpackage

// File: rtl/riscv.sv
// riscv: architectural widths shared by the frontend and execute stages.
//   VLEN - virtual address width carried on fetch and resolution paths.
package riscv;

    localparam int unsigned VLEN = 64;

endpackage

// File: rtl/bht_sat_counter.sv
// bht_sat_counter: combinational next-state function of one BHT row counter.
//   ctr_i   - current 2-bit counter of the row.
//   valid_i - row valid bit; an invalid row is (re)seeded in a weak state.
//   taken_i - resolved branch direction.
//   ctr_o   - counter value to write back.
module bht_sat_counter
    import bht_resolve_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       valid_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (!valid_i) begin
            // First training of a row lands in the weak state of its direction.
            ctr_o = taken_i ? CTR_WEAK_T : CTR_WEAK_NT;
        end else if (taken_i) begin
            if (ctr_i != CTR_STRONG_T) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != CTR_STRONG_NT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bht_resolve.sv
// bht_resolve: branch history table trained by resolved conditional branches
// and looked up by fetch.
//   clk_i             - clock.
//   rst_i             - synchronous active-high reset; starts a clear sweep.
//   flush_bp_i        - starts or restarts a full-table clear sweep.
//   debug_mode_i      - drops all training while high.
//   lookup_valid_i    - fetch lookup request this cycle.
//   vpc_i             - virtual PC of the lookup.
//   resolved_branch_i - resolution record from the branch unit.
//   resolve_cond_i    - marks resolved_branch_i as a conditional branch.
//   bht_prediction_o  - registered {valid, taken}, one cycle after the lookup.
//   busy_o            - high while the clear sweep runs.
// Handshake: there is no back-pressure; a lookup or resolution presented in
// RUN is consumed at that clock edge, and the prediction appears one cycle
// later for exactly one cycle.
module bht_resolve
    import ariane_pkg::*;
    import bht_resolve_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = 64,
    parameter int unsigned ROW_ADDR_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_bp_i,
    input  logic                   debug_mode_i,
    input  logic                   lookup_valid_i,
    input  logic [riscv::VLEN-1:0] vpc_i,
    input  bp_resolve_t            resolved_branch_i,
    input  logic                   resolve_cond_i,
    output bht_pred_t              bht_prediction_o,
    output logic                   busy_o
);

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_row_t;

    localparam logic [ROW_ADDR_BITS-1:0] LAST_IDX = ROW_ADDR_BITS'(NR_ENTRIES - 1);

    bht_row_t                 rows_q [NR_ENTRIES];
    bht_state_e               state_q, state_d;
    logic [ROW_ADDR_BITS-1:0] idx_q, idx_d;
    bht_pred_t                pred_q, pred_d;

    logic                     sweep_clear;
    logic                     train_en;
    logic [ROW_ADDR_BITS-1:0] lookup_idx;
    logic [ROW_ADDR_BITS-1:0] train_idx;
    bht_row_t                 lookup_row;
    bht_row_t                 train_row;
    logic [1:0]               train_ctr;

    // Halfword granularity: bit 0 never selects a row.
    assign lookup_idx = vpc_i[ROW_ADDR_BITS:1];
    assign train_idx  = resolved_branch_i.pc[ROW_ADDR_BITS:1];
    assign lookup_row = rows_q[lookup_idx];
    assign train_row  = rows_q[train_idx];

    bht_sat_counter u_sat_counter (
        .ctr_i   (train_row.ctr),
        .valid_i (train_row.valid),
        .taken_i (resolved_branch_i.cf_type.taken),
        .ctr_o   (train_ctr)
    );

    // Sweep control. A flush in either state restarts the sweep at row 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sweep_clear = 1'b0;
        case (state_q)
            FLUSH: begin
                sweep_clear = 1'b1;
                if (flush_bp_i) begin
                    idx_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ROW_ADDR_BITS'(1);
                end
            end
            RUN: begin
                if (flush_bp_i) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = FLUSH;
                idx_d   = '0;
            end
        endcase
    end

    // A flush in the same cycle wins over training.
    assign train_en = resolved_branch_i.valid && resolve_cond_i && !debug_mode_i
                      && (state_q == RUN) && !flush_bp_i;

    // The prediction register is zeroed whenever the next cycle is a sweep
    // cycle, so the output never shows a lookup result while busy.
    always_comb begin
        pred_d       = '0;
        pred_d.valid = (state_q == RUN) && !flush_bp_i && lookup_valid_i && lookup_row.valid;
        pred_d.taken = pred_d.valid && lookup_row.ctr[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FLUSH;
            idx_q   <= '0;
            pred_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pred_q  <= pred_d;
        end
    end

    // Table rows carry no reset; the sweep is the only way they are cleared.
    // Reads above use the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (sweep_clear) begin
                rows_q[idx_q] <= '0;
            end else if (train_en) begin
                rows_q[train_idx] <= '{valid: 1'b1, ctr: train_ctr};
            end
        end
    end

    assign bht_prediction_o = pred_q;
    assign busy_o           = (state_q == FLUSH);

    logic unused_bits;
    assign unused_bits = ^{vpc_i[riscv::VLEN-1:ROW_ADDR_BITS+1], vpc_i[0],
                           resolved_branch_i.pc[riscv::VLEN-1:ROW_ADDR_BITS+1],
                           resolved_branch_i.pc[0],
                           resolved_branch_i.target_address,
                           resolved_branch_i.is_mispredict,
                           resolved_branch_i.to_reg,
                           resolved_branch_i.cf_type.kind};

endmodule
